mem_cycle_arbiter: RTL and testbench
====================================

// Module: mem_cycle_arbiter
// PURPOSE
//   Owns the single 32k x 12 core-memory model and shares it between the CPU and a data-break
//   (DMA) requester. Sequences each memory cycle: start handshake, done wait and release.
//   Supplies the read-restore write-back data, since every core cycle rewrites its location.
//   Sits between the CPU/break logic and the memory model.
// PARAMETERS
//   ADDR_W   15   memory address width
//   DATA_W   12   memory word width
//   BRK_MAX  4    consecutive break cycles allowed while cpu_req is pending; then CPU gets one
//   TIMEOUT  255  clocks allowed from mem_start rise to mem_done_n low before abort
// PORTS
//   clk          in   1       system clock, 100 MHz
//   rst_n        in   1       asynchronous active-low reset
//   cpu_req      in   1       CPU cycle request, level; held until cpu_ack
//   cpu_we       in   1       1 = write cpu_wdata, 0 = read/restore
//   cpu_addr     in   ADDR_W  CPU address
//   cpu_wdata    in   DATA_W  CPU write data
//   cpu_ack      out  1       one-clock pulse at cycle completion
//   cpu_rdata    out  DATA_W  word read (old contents); valid with cpu_ack, held until next CPU ack
//   brk_req/brk_we/brk_addr/brk_wdata/brk_ack/brk_rdata   same set for the data-break port
//   mem_start    out  1       to memory; the rising edge starts a cycle
//   mem_done_n   in   1       from memory; low = cycle complete (stays low until next start)
//   mem_addr     out  ADDR_W  to memory; held for the whole cycle
//   mem_wdata    out  DATA_W  to memory data_in
//   mem_rdata    in   DATA_W  from memory data_out
//   grant_brk    out  1       1 while the current or last cycle belongs to break
//   busy         out  1       1 in any state other than IDLE
//   timeout_err  out  1       sticky; set on watchdog abort; cleared only by reset
// BEHAVIOUR
//   - Reset: state IDLE. All outputs 0, including mem_start, acks, rdata, mem_addr, mem_wdata,
//     grant_brk, busy, timeout_err, and the break run counter.
//   - States:
//     * IDLE: arbitrate when any request is present.
//       - Priority: brk > cpu.
//       - Exception: if cpu_req=1 and brk_run==BRK_MAX, the CPU wins.
//       - Winner's addr, we and wdata are latched into registers; grant_brk is set accordingly.
//       - Next state START.
//     * START: mem_start=1 and watchdog cleared. Stay until mem_done_n==1, which clears the stale
//       done from the previous cycle (about 2 clocks). Then go to WAIT_DONE.
//     * WAIT_DONE: mem_start stays 1. On mem_done_n==0: latch mem_rdata into the winner's rdata,
//       pulse the winner's ack for 1 clock, then go to RELEASE.
//     * RELEASE: mem_start=0 for exactly 1 clock so the next rising edge is detectable.
//       Then go to IDLE. Back-to-back cycles: IDLE->START without extra idle clocks.
//   - Write-back data:
//     * mem_wdata = latched wdata when latched we=1.
//     * mem_wdata = mem_rdata when we=0 (restore).
//     * mem_wdata is combinational from the latched we, so the memory write sees valid data.
//   - mem_addr and the latched we/wdata are stable from START entry through RELEASE. Requester
//     inputs may change after arbitration without effect.
//   - Break run counter (brk_run):
//     * Increments on a break grant made while cpu_req=1; saturates at BRK_MAX.
//     * Clears on any CPU grant.
//     * Clears when a break is granted with cpu_req=0.
//   - Watchdog:
//     * Counts clocks in START and WAIT_DONE.
//     * On reaching TIMEOUT: set timeout_err, drop mem_start, go to RELEASE.
//     * No ack is issued on a timeout. The request stays pending and is re-arbitrated.
//   - Simultaneous requests in IDLE: exactly one grant; the loser waits, with no ack and no lost
//     request.
//   - A request dropped before its ack is a requester protocol error. The arbiter completes the
//     cycle anyway and still acks.
//   - Reset mid-cycle: immediate return to IDLE, mem_start=0, no ack. The memory contents of the
//     aborted address are undefined.
//   - Latency: request seen in IDLE at clock T gives mem_start=1 at T+1. The ack arrives about
//     152 clocks later with the 1.5 us memory model.
// TESTING
//   - CPU read: preload ram[0o1234]=0o5252; cpu_req, we=0, addr=0o1234 -> one cpu_ack,
//     cpu_rdata=0o5252, ram unchanged (restore), one mem_start rise.
//   - CPU write: we=1, addr=0o0200, wdata=0o7001 -> ack; a following read returns 0o7001;
//     cpu_rdata holds the old contents.
//   - Contention: cpu_req and brk_req rise on the same clock -> break is served first, then CPU;
//     both ack once; grant_brk is 1 then 0.
//   - Starvation guard (BRK_MAX=4): brk_req held high with cpu_req pending -> 4 break acks,
//     then 1 CPU ack, then break resumes.
//   - Timeout: force mem_done_n stuck at 1 -> after 255 clocks timeout_err=1, mem_start=0,
//     no ack; release the force -> the cycle retries and completes.
//   - Reset mid-WAIT_DONE: assert rst_n=0 -> all outputs 0 asynchronously; after release,
//     a new request completes normally.

Source files
------------

// File: rtl/mem_cycle_arbiter.sv
// Shares one core-memory model between the CPU and the data-break port, sequencing each
// start/done/release handshake and supplying read-restore write-back data.
module mem_cycle_arbiter #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned BRK_MAX = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              brk_req,
    input  logic              brk_we,
    input  logic [ADDR_W-1:0] brk_addr,
    input  logic [DATA_W-1:0] brk_wdata,
    output logic              brk_ack,
    output logic [DATA_W-1:0] brk_rdata,
    output logic              mem_start,
    input  logic              mem_done_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_brk,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned RUN_W = $clog2(BRK_MAX + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cyc_t;

    state_t            state_q, state_d;
    cyc_t              cyc_q, cyc_d;
    logic [RUN_W-1:0]  brk_run_q, brk_run_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              mem_start_d, busy_d, grant_brk_d, timeout_err_d;
    logic              cpu_ack_d, brk_ack_d;
    logic [DATA_W-1:0] cpu_rdata_d, brk_rdata_d;

    logic any_req, pick_brk, done_hit, wd_expire, timeout_fire;

    // Break normally wins, except once it has starved a pending CPU for BRK_MAX cycles.
    assign any_req      = cpu_req | brk_req;
    assign pick_brk     = brk_req & ~(cpu_req & (brk_run_q == RUN_W'(BRK_MAX)));
    assign done_hit     = (state_q == WAIT_DONE) & ~mem_done_n;
    assign wd_expire    = (wdog_q == WD_W'(TIMEOUT - 1));
    assign timeout_fire = wd_expire & ((state_q == START) | ((state_q == WAIT_DONE) & mem_done_n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (any_req) state_d = START;
            START:     if (timeout_fire) state_d = RELEASE;
                       else if (mem_done_n) state_d = WAIT_DONE;
            WAIT_DONE: if (done_hit || timeout_fire) state_d = RELEASE;
            RELEASE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d         = cyc_q;
        grant_brk_d   = grant_brk;
        brk_run_d     = brk_run_q;
        cpu_rdata_d   = cpu_rdata;
        brk_rdata_d   = brk_rdata;
        cpu_ack_d     = 1'b0;
        brk_ack_d     = 1'b0;
        timeout_err_d = timeout_err | timeout_fire;
        mem_start_d   = (state_d == START) || (state_d == WAIT_DONE);
        busy_d        = (state_d != IDLE);
        wdog_d        = ((state_q == START) || (state_q == WAIT_DONE)) ? wdog_q + WD_W'(1) : '0;

        if ((state_q == IDLE) && any_req) begin
            grant_brk_d = pick_brk;
            if (pick_brk) begin
                cyc_d = '{we: brk_we, addr: brk_addr, wdata: brk_wdata};
                if (!cpu_req) begin
                    brk_run_d = '0;
                end else if (brk_run_q != RUN_W'(BRK_MAX)) begin
                    brk_run_d = brk_run_q + RUN_W'(1);
                end
            end else begin
                cyc_d     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                brk_run_d = '0;
            end
        end

        if (done_hit) begin
            if (grant_brk) begin
                brk_ack_d   = 1'b1;
                brk_rdata_d = mem_rdata;
            end else begin
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q       <= '0;
            brk_run_q   <= '0;
            wdog_q      <= '0;
            mem_start   <= 1'b0;
            busy        <= 1'b0;
            grant_brk   <= 1'b0;
            timeout_err <= 1'b0;
            cpu_ack     <= 1'b0;
            brk_ack     <= 1'b0;
            cpu_rdata   <= '0;
            brk_rdata   <= '0;
        end else begin
            cyc_q       <= cyc_d;
            brk_run_q   <= brk_run_d;
            wdog_q      <= wdog_d;
            mem_start   <= mem_start_d;
            busy        <= busy_d;
            grant_brk   <= grant_brk_d;
            timeout_err <= timeout_err_d;
            cpu_ack     <= cpu_ack_d;
            brk_ack     <= brk_ack_d;
            cpu_rdata   <= cpu_rdata_d;
            brk_rdata   <= brk_rdata_d;
        end
    end

    // Restore cycles write back the word just read; write data must track mem_rdata directly.
    assign mem_addr  = cyc_q.addr;
    assign mem_wdata = (state_q == IDLE) ? '0 : (cyc_q.we ? cyc_q.wdata : mem_rdata);

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// Bench for mem_cycle_arbiter: small read-restore core model plus an expected-ack scoreboard.
module tb_mem_cycle_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [11:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [11:0] cpu_rdata;
    logic        brk_req = 1'b0, brk_we = 1'b0;
    logic [14:0] brk_addr = '0;
    logic [11:0] brk_wdata = '0;
    logic        brk_ack;
    logic [11:0] brk_rdata;
    logic        mem_start;
    logic        mem_done_n = 1'b0;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic        grant_brk, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_brk;
        logic [11:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_cycle_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .brk_req(brk_req), .brk_we(brk_we), .brk_addr(brk_addr), .brk_wdata(brk_wdata),
        .brk_ack(brk_ack), .brk_rdata(brk_rdata),
        .mem_start(mem_start), .mem_done_n(mem_done_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_brk(grant_brk), .busy(busy), .timeout_err(timeout_err)
    );

    // Core memory model: stale done clears, read, then write-back with done low until next start.
    logic [11:0] ram [0:32767];
    logic        prev_start = 1'b0;
    int          m_phase = 0;
    int          start_rises = 0;
    bit          stuck = 1'b0;
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [11:0] pre_data = '0;

    always @(posedge clk) begin
        prev_start <= mem_start;
        if (pre_we) ram[pre_addr] <= pre_data;
        if (!mem_start) begin
            m_phase <= 0;
        end else if (!prev_start) begin
            m_phase     <= 1;
            start_rises <= start_rises + 1;
        end else if (m_phase != 0) begin
            if (m_phase == 2) mem_done_n <= 1'b1;
            if (m_phase == 4) mem_rdata <= ram[mem_addr];
            if (m_phase == 6) begin
                if (!stuck) begin
                    ram[mem_addr] <= mem_wdata;
                    mem_done_n    <= 1'b0;
                    m_phase       <= 0;
                end
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit got, output bit isb,
                            output logic [11:0] rd);
        got = 1'b0;
        isb = 1'b0;
        rd  = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                got = 1'b1; isb = 1'b0; rd = cpu_rdata;
            end else if (brk_ack === 1'b1) begin
                got = 1'b1; isb = 1'b1; rd = brk_rdata;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, brk_ack, mem_start, grant_brk, busy, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {cpu_ack, brk_ack, mem_start, grant_brk, busy, timeout_err});
        end
        n_checks++;
        if ({cpu_rdata, brk_rdata, mem_addr, mem_wdata} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_data cpu_rdata=%o brk_rdata=%o mem_addr=%o mem_wdata=%o want 0",
                     cpu_rdata, brk_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_cpu_read;
        bit got, isb;
        logic [11:0] rd;
        int rises0;
        exp_t e;
        preload(15'o1234, 12'o5252);
        rises0 = start_rises;
        sb.push_back('{is_brk: 1'b0, rdata: 12'o5252});
        cpu_we = 1'b0; cpu_addr = 15'o1234; cpu_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_start !== 1'b1 || busy !== 1'b1 || mem_addr !== 15'o1234 || grant_brk !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency start=%b busy=%b addr=%o grant_brk=%b want 1 1 1234 0",
                     mem_start, busy, mem_addr, grant_brk);
        end
        wait_ack(100, got, isb, rd);
        cpu_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || isb !== e.is_brk || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL read_ack got=%b brk=%b rdata=%o want 1 %b %o", got, isb, rd, e.is_brk, e.rdata);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack_pulse cpu_ack=%b want 0", cpu_ack);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ram[15'o1234] !== 12'o5252 || start_rises - rises0 != 1) begin
            n_fail++;
            $display("FAIL read_restore ram=%o rises=%0d want 5252 1", ram[15'o1234], start_rises - rises0);
        end
    endtask

    task automatic test_cpu_write;
        bit got, isb;
        logic [11:0] rd;
        exp_t e;
        preload(15'o0200, 12'o1111);
        sb.push_back('{is_brk: 1'b0, rdata: 12'o1111});
        sb.push_back('{is_brk: 1'b0, rdata: 12'o7001});
        cpu_we = 1'b1; cpu_addr = 15'o0200; cpu_wdata = 12'o7001; cpu_req = 1'b1;
        wait_ack(100, got, isb, rd);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        e = sb.pop_front();
        n_checks++;
        if (!got || isb !== e.is_brk || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL write_ack got=%b brk=%b rdata=%o want 1 %b %o", got, isb, rd, e.is_brk, e.rdata);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 12'o1111 || ram[15'o0200] !== 12'o7001) begin
            n_fail++;
            $display("FAIL write_hold cpu_rdata=%o ram=%o want 1111 7001", cpu_rdata, ram[15'o0200]);
        end
        cpu_req = 1'b1;
        wait_ack(100, got, isb, rd);
        cpu_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || isb !== e.is_brk || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL write_readback got=%b brk=%b rdata=%o want 1 %b %o", got, isb, rd, e.is_brk, e.rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention;
        bit got, isb;
        logic [11:0] rd;
        exp_t e;
        preload(15'o3000, 12'o0044);
        preload(15'o3001, 12'o0033);
        sb.push_back('{is_brk: 1'b1, rdata: 12'o0033});
        sb.push_back('{is_brk: 1'b0, rdata: 12'o0044});
        cpu_we = 1'b0; cpu_addr = 15'o3000;
        brk_we = 1'b1; brk_addr = 15'o3001; brk_wdata = 12'o6666;
        cpu_req = 1'b1; brk_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(100, got, isb, rd);
            if (isb) brk_req = 1'b0; else cpu_req = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (!got || isb !== e.is_brk || rd !== e.rdata || grant_brk !== e.is_brk) begin
                n_fail++;
                $display("FAIL contention_%0d got=%b brk=%b grant_brk=%b rdata=%o want 1 %b %b %o",
                         k, got, isb, grant_brk, rd, e.is_brk, e.is_brk, e.rdata);
            end
        end
        brk_we = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ram[15'o3001] !== 12'o6666 || cpu_ack !== 1'b0 || brk_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_tail ram=%o acks=%b%b want 6666 00", ram[15'o3001], cpu_ack, brk_ack);
        end
    endtask

    task automatic test_starvation;
        bit got, isb;
        logic [11:0] rd;
        exp_t e;
        preload(15'o4000, 12'o0101);
        preload(15'o4001, 12'o0202);
        for (int k = 0; k < 4; k++) sb.push_back('{is_brk: 1'b1, rdata: 12'o0101});
        sb.push_back('{is_brk: 1'b0, rdata: 12'o0202});
        sb.push_back('{is_brk: 1'b1, rdata: 12'o0101});
        cpu_we = 1'b0; cpu_addr = 15'o4001;
        brk_we = 1'b0; brk_addr = 15'o4000;
        cpu_req = 1'b1; brk_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(100, got, isb, rd);
            if (!isb) cpu_req = 1'b0;
            if (k == 5) brk_req = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (!got || isb !== e.is_brk || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL starve_%0d got=%b brk=%b rdata=%o want 1 %b %o", k, got, isb, rd, e.is_brk, e.rdata);
            end
        end
        cpu_req = 1'b0; brk_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit got, isb, early_ack;
        logic [11:0] rd;
        int hi;
        exp_t e;
        preload(15'o0400, 12'o2525);
        sb.push_back('{is_brk: 1'b0, rdata: 12'o2525});
        stuck = 1'b1;
        hi = 0;
        early_ack = 1'b0;
        cpu_we = 1'b0; cpu_addr = 15'o0400; cpu_req = 1'b1;
        @(negedge clk);
        while (mem_start === 1'b1 && hi < 400) begin
            hi++;
            if (cpu_ack === 1'b1 || brk_ack === 1'b1) early_ack = 1'b1;
            @(negedge clk);
        end
        stuck = 1'b0;
        n_checks++;
        if (hi != 255 || mem_start !== 1'b0 || timeout_err !== 1'b1 || early_ack) begin
            n_fail++;
            $display("FAIL timeout clocks=%0d start=%b timeout_err=%b ack_seen=%b want 255 0 1 0",
                     hi, mem_start, timeout_err, early_ack);
        end
        wait_ack(100, got, isb, rd);
        cpu_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || isb !== e.is_brk || rd !== e.rdata || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_retry got=%b brk=%b rdata=%o err=%b want 1 %b %o 1",
                     got, isb, rd, timeout_err, e.is_brk, e.rdata);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit got, isb;
        logic [11:0] rd;
        exp_t e;
        preload(15'o5000, 12'o0707);
        preload(15'o5001, 12'o1357);
        cpu_we = 1'b0; cpu_addr = 15'o5000; cpu_req = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midcycle_pre start=%b busy=%b want 1 1", mem_start, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ack, brk_ack, mem_start, grant_brk, busy, timeout_err} !== 6'b0 ||
            {cpu_rdata, brk_rdata, mem_addr, mem_wdata} !== 51'd0) begin
            n_fail++;
            $display("FAIL midcycle_reset ctrl=%b rdata=%o/%o addr=%o wdata=%o want all 0",
                     {cpu_ack, brk_ack, mem_start, grant_brk, busy, timeout_err},
                     cpu_rdata, brk_rdata, mem_addr, mem_wdata);
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{is_brk: 1'b0, rdata: 12'o1357});
        cpu_addr = 15'o5001; cpu_req = 1'b1;
        wait_ack(100, got, isb, rd);
        cpu_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!got || isb !== e.is_brk || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL after_reset got=%b brk=%b rdata=%o want 1 %b %o", got, isb, rd, e.is_brk, e.rdata);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_contention();
        test_starvation();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left entries=%0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
